// File: rtl/secded_pkg.sv
// -----------------------------------------------------------------------------
// secded_pkg
// Shared definitions for the SECDED-protected SPI slave:
//   - err_class_e : decode outcome (CLEAN, SEC = corrected, DED = uncorrectable)
//   - calc_par_w  : number of Hamming parity bits for a given payload width
//   - is_pow2     : true for codeword positions that carry Hamming parity
//   - data_pos    : payload bit index -> codeword position
//   - pos_to_idx  : codeword position  -> payload bit index (data positions only)
// Codeword layout: position 0 = overall even parity, positions 2^j = Hamming
// parity, remaining positions (3, 5, 6, 7, 9, ...) = payload, LSB first.
// -----------------------------------------------------------------------------
package secded_pkg;

    typedef enum logic [1:0] {
        CLEAN = 2'd0,
        SEC   = 2'd1,
        DED   = 2'd2
    } err_class_e;

    // Smallest p with 2^p >= data_w + p + 1.
    function automatic int calc_par_w(input int data_w);
        int p;
        p = 1;
        for (int k = 1; k < 31; k++) begin
            if ((1 << p) < data_w + p + 1) begin
                p = p + 1;
            end
        end
        return p;
    endfunction

    function automatic bit is_pow2(input int k);
        return (k > 0) && ((k & (k - 1)) == 0);
    endfunction

    // Position of payload bit idx: the idx-th non-power-of-two position >= 3.
    function automatic int data_pos(input int idx);
        int pos;
        int cnt;
        pos = 0;
        cnt = 0;
        for (int k = 3; k < 2 * idx + 8; k++) begin
            if (!is_pow2(k)) begin
                if (cnt == idx) begin
                    pos = k;
                end
                cnt = cnt + 1;
            end
        end
        return pos;
    endfunction

    // Inverse of data_pos for a position known to carry payload.
    function automatic int pos_to_idx(input int pos);
        int cnt;
        cnt = 0;
        for (int k = 3; k < pos; k++) begin
            if (!is_pow2(k)) begin
                cnt = cnt + 1;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/secded_codec.sv
// -----------------------------------------------------------------------------
// secded_codec
// Purely combinational extended-Hamming (SECDED) encoder and decoder.
// Ports:
//   enc_data_i  [DATA_W]  payload to encode
//   enc_cw_o    [FRAME_W] encoded codeword
//   dec_cw_i    [FRAME_W] received codeword
//   dec_data_o  [DATA_W]  decoded (corrected where possible) payload
//   dec_class_o           CLEAN / SEC / DED
// -----------------------------------------------------------------------------
module secded_codec
    import secded_pkg::*;
#(
    parameter  int DATA_W  = 11,
    localparam int PAR_W   = calc_par_w(DATA_W),
    localparam int FRAME_W = DATA_W + PAR_W + 1
) (
    input  logic [DATA_W-1:0]  enc_data_i,
    output logic [FRAME_W-1:0] enc_cw_o,
    input  logic [FRAME_W-1:0] dec_cw_i,
    output logic [DATA_W-1:0]  dec_data_o,
    output err_class_e         dec_class_o
);

    // ---------------- encoder ----------------
    logic [FRAME_W-1:0] spread;
    logic [PAR_W-1:0]   enc_par;

    for (genvar gk = 0; gk < FRAME_W; gk++) begin : g_spread
        if (gk >= 3 && !is_pow2(gk)) begin : g_data
            assign spread[gk] = enc_data_i[pos_to_idx(gk)];
        end else begin : g_fixed
            assign spread[gk] = 1'b0;
        end
    end

    // Parity bits are chosen so the XOR of all set-bit indices becomes zero,
    // i.e. they equal the XOR of the indices of the set payload bits.
    always_comb begin
        enc_par = '0;
        for (int k = 1; k < FRAME_W; k++) begin
            if (spread[k]) begin
                enc_par = enc_par ^ PAR_W'(k);
            end
        end
    end

    always_comb begin
        enc_cw_o = spread;
        for (int j = 0; j < PAR_W; j++) begin
            enc_cw_o[1 << j] = enc_par[j];
        end
        enc_cw_o[0] = ^enc_cw_o[FRAME_W-1:1];
    end

    // ---------------- decoder ----------------
    logic [PAR_W-1:0] syn;
    logic             q;
    logic             flip_en;

    always_comb begin
        syn = '0;
        for (int k = 1; k < FRAME_W; k++) begin
            if (dec_cw_i[k]) begin
                syn = syn ^ PAR_W'(k);
            end
        end
        q = ^dec_cw_i;
    end

    // A syndrome pointing past the last position cannot come from a single
    // flip in the shortened code, so it is reported as uncorrectable.
    always_comb begin
        dec_class_o = CLEAN;
        flip_en     = 1'b0;
        if (q) begin
            if (syn == '0) begin
                dec_class_o = SEC;
            end else if (int'(syn) < FRAME_W) begin
                dec_class_o = SEC;
                flip_en     = 1'b1;
            end else begin
                dec_class_o = DED;
            end
        end else if (syn != '0) begin
            dec_class_o = DED;
        end
    end

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_extract
        assign dec_data_o[gi] = dec_cw_i[data_pos(gi)]
                              ^ (flip_en && (syn == PAR_W'(data_pos(gi))));
    end

endmodule

// File: rtl/spi_slave_secded.sv
// -----------------------------------------------------------------------------
// spi_slave_secded
// SPI slave clocked directly by the system clock, SECDED-protected both ways.
// Ports:
//   clk_in          serial bit clock / system clock (posedge)
//   reset           asynchronous, active-high
//   ss              slave select, active-high; low aborts any partial frame
//   msg_in          serial data in (sampled while ss=1)
//   msg_out_tri     serial data out, high-Z while ss=0
//   data_from_peri  transmit payload, written to tx_hold by tx_we
//   tx_we           transmit holding register write enable
//   data_to_peri    last clean/corrected receive payload
//   rx_valid        one-cycle strobe per decoded frame
//   single_err      last frame was corrected
//   double_err      last frame was uncorrectable
//   sec_cnt/ded_cnt saturating corrected/uncorrectable frame counters
//   cnt_clr         synchronous clear of both counters (wins over increment)
// -----------------------------------------------------------------------------
module spi_slave_secded
    import secded_pkg::*;
#(
    parameter  int DATA_W    = 11,
    parameter  bit MSB_FIRST = 1'b1,
    parameter  int CNT_W     = 8,
    localparam int PAR_W     = calc_par_w(DATA_W),
    localparam int FRAME_W   = DATA_W + PAR_W + 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              ss,
    input  logic              msg_in,
    output logic              msg_out_tri,
    input  logic [DATA_W-1:0] data_from_peri,
    input  logic              tx_we,
    output logic [DATA_W-1:0] data_to_peri,
    output logic              rx_valid,
    output logic              single_err,
    output logic              double_err,
    output logic [CNT_W-1:0]  sec_cnt,
    output logic [CNT_W-1:0]  ded_cnt,
    input  logic              cnt_clr
);

    localparam int              BC_W      = $clog2(FRAME_W);
    localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(FRAME_W - 1);
    localparam int              FIRST_POS = MSB_FIRST ? FRAME_W - 1 : 0;

    logic [BC_W-1:0]    bit_cnt_q,  bit_cnt_d;
    logic [DATA_W-1:0]  tx_hold_q,  tx_hold_d;
    logic [FRAME_W-1:0] tx_sr_q,    tx_sr_d;
    logic [FRAME_W-1:0] rx_sr_q,    rx_sr_d;
    logic               done_q,     done_d;
    logic [DATA_W-1:0]  data_q,     data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               sec_q,      sec_d;
    logic               ded_q,      ded_d;
    logic [CNT_W-1:0]   sec_cnt_q,  sec_cnt_d;
    logic [CNT_W-1:0]   ded_cnt_q,  ded_cnt_d;

    logic [DATA_W-1:0]  tx_src;
    logic [FRAME_W-1:0] tx_cw;
    logic [FRAME_W-1:0] rx_shift;
    logic [DATA_W-1:0]  rx_data;
    err_class_e         rx_class;
    logic               frame_start;
    logic               tx_bit;

    logic [DATA_W-1:0]  tx_unused_data;
    err_class_e         tx_unused_class;
    logic [FRAME_W-1:0] rx_unused_cw;

    // A write landing on bit 0 is bypassed straight into the encoder so the
    // frame starting now already carries the new payload.
    assign tx_src = tx_we ? data_from_peri : tx_hold_q;

    secded_codec #(.DATA_W(DATA_W)) u_tx_codec (
        .enc_data_i  (tx_src),
        .enc_cw_o    (tx_cw),
        .dec_cw_i    ('0),
        .dec_data_o  (tx_unused_data),
        .dec_class_o (tx_unused_class)
    );

    secded_codec #(.DATA_W(DATA_W)) u_rx_codec (
        .enc_data_i  ('0),
        .enc_cw_o    (rx_unused_cw),
        .dec_cw_i    (rx_sr_q),
        .dec_data_o  (rx_data),
        .dec_class_o (rx_class)
    );

    function automatic logic [FRAME_W-1:0] advance(input logic [FRAME_W-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign frame_start = (bit_cnt_q == '0);

    // During bit 0 the first codeword bit comes directly from the encoder;
    // the shift register holds the remaining bits from bit 1 onwards.
    assign tx_bit      = frame_start ? tx_cw[FIRST_POS] : tx_sr_q[FIRST_POS];
    assign msg_out_tri = ss ? tx_bit : 1'bz;

    assign rx_shift = MSB_FIRST ? {rx_sr_q[FRAME_W-2:0], msg_in}
                                : {msg_in, rx_sr_q[FRAME_W-1:1]};

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        tx_hold_d  = tx_hold_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        done_d     = 1'b0;
        data_d     = data_q;
        rx_valid_d = 1'b0;
        sec_d      = sec_q;
        ded_d      = ded_q;
        sec_cnt_d  = sec_cnt_q;
        ded_cnt_d  = ded_cnt_q;

        if (tx_we) begin
            tx_hold_d = data_from_peri;
        end

        if (ss) begin
            bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + 1'b1;
            tx_sr_d   = advance(frame_start ? tx_cw : tx_sr_q);
            rx_sr_d   = rx_shift;
            done_d    = (bit_cnt_q == LAST_BIT);
        end else begin
            bit_cnt_d = '0;
        end

        // The word completed on the previous edge sits whole in rx_sr_q now,
        // even if the next frame has already started shifting.
        if (done_q) begin
            rx_valid_d = 1'b1;
            sec_d      = (rx_class == SEC);
            ded_d      = (rx_class == DED);
            if (rx_class != DED) begin
                data_d = rx_data;
            end
        end

        if (cnt_clr) begin
            sec_cnt_d = '0;
            ded_cnt_d = '0;
        end else if (done_q) begin
            if (rx_class == SEC && sec_cnt_q != '1) begin
                sec_cnt_d = sec_cnt_q + 1'b1;
            end
            if (rx_class == DED && ded_cnt_q != '1) begin
                ded_cnt_d = ded_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            bit_cnt_q  <= '0;
            tx_hold_q  <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            done_q     <= 1'b0;
            data_q     <= '0;
            rx_valid_q <= 1'b0;
            sec_q      <= 1'b0;
            ded_q      <= 1'b0;
            sec_cnt_q  <= '0;
            ded_cnt_q  <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            tx_hold_q  <= tx_hold_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            done_q     <= done_d;
            data_q     <= data_d;
            rx_valid_q <= rx_valid_d;
            sec_q      <= sec_d;
            ded_q      <= ded_d;
            sec_cnt_q  <= sec_cnt_d;
            ded_cnt_q  <= ded_cnt_d;
        end
    end

    assign data_to_peri = data_q;
    assign rx_valid     = rx_valid_q;
    assign single_err   = sec_q;
    assign double_err   = ded_q;
    assign sec_cnt      = sec_cnt_q;
    assign ded_cnt      = ded_cnt_q;

endmodule

// File: tb/tb_spi_slave_secded.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_secded
// Two instances share all inputs: one with 8-bit counters, one with 2-bit
// counters (saturation). A reference model built from the codeword rules
// (payload placement, index-XOR syndrome, overall parity) predicts the serial
// output and every registered result.
// -----------------------------------------------------------------------------
module tb_spi_slave_secded;

    localparam int DW = 11;
    localparam int FW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          ss;
    logic          msg_in;
    logic          tx_we;
    logic          cnt_clr;
    logic [DW-1:0] data_from_peri;

    logic          mo_a, mo_b;
    logic [DW-1:0] dtp_a, dtp_b;
    logic          rv_a, rv_b, se_a, se_b, de_a, de_b;
    logic [7:0]    sc_a, dc_a;
    logic [1:0]    sc_b, dc_b;

    always #5 clk = ~clk;

    spi_slave_secded #(.DATA_W(DW), .MSB_FIRST(1'b1), .CNT_W(8)) dut_a (
        .clk_in(clk), .reset(reset), .ss(ss), .msg_in(msg_in), .msg_out_tri(mo_a),
        .data_from_peri(data_from_peri), .tx_we(tx_we), .data_to_peri(dtp_a),
        .rx_valid(rv_a), .single_err(se_a), .double_err(de_a),
        .sec_cnt(sc_a), .ded_cnt(dc_a), .cnt_clr(cnt_clr)
    );

    spi_slave_secded #(.DATA_W(DW), .MSB_FIRST(1'b1), .CNT_W(2)) dut_b (
        .clk_in(clk), .reset(reset), .ss(ss), .msg_in(msg_in), .msg_out_tri(mo_b),
        .data_from_peri(data_from_peri), .tx_we(tx_we), .data_to_peri(dtp_b),
        .rx_valid(rv_b), .single_err(se_b), .double_err(de_b),
        .sec_cnt(sc_b), .ded_cnt(dc_b), .cnt_clr(cnt_clr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int            dpos[DW];
    logic [DW-1:0] m_hold;
    logic [DW-1:0] m_data;
    logic          m_se, m_de;
    int            m_sc8, m_dc8, m_sc2, m_dc2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] mdl_encode(input logic [DW-1:0] d);
        logic [FW-1:0] c;
        logic          x;
        c = '0;
        for (int i = 0; i < DW; i++) c[dpos[i]] = d[i];
        for (int pb = 1; pb < FW; pb = pb * 2) begin
            x = 1'b0;
            for (int p = 1; p < FW; p++) if (p != pb && (p & pb) != 0) x = x ^ c[p];
            c[pb] = x;
        end
        c[0] = ^c[FW-1:1];
        return c;
    endfunction

    // cls: 0 clean, 1 corrected, 2 uncorrectable
    task automatic mdl_decode(input logic [FW-1:0] cw, output int cls, output logic [DW-1:0] d);
        int s;
        int q;
        logic [FW-1:0] c;
        s = 0;
        q = 0;
        for (int p = 0; p < FW; p++) if (cw[p]) q = q ^ 1;
        for (int p = 1; p < FW; p++) if (cw[p]) s = s ^ p;
        c = cw;
        cls = 0;
        if (q == 1) begin
            cls = 1;
            if (s >= FW) cls = 2;
            else if (s != 0) c[s] = ~c[s];
        end else if (s != 0) begin
            cls = 2;
        end
        for (int i = 0; i < DW; i++) d[i] = c[dpos[i]];
    endtask

    task automatic chk_outs(input string tag, input logic exp_rv);
        chk({tag, ".rv_a"},   32'(rv_a),  32'(exp_rv));
        chk({tag, ".rv_b"},   32'(rv_b),  32'(exp_rv));
        chk({tag, ".data_a"}, 32'(dtp_a), 32'(m_data));
        chk({tag, ".data_b"}, 32'(dtp_b), 32'(m_data));
        chk({tag, ".se_a"},   32'(se_a),  32'(m_se));
        chk({tag, ".de_a"},   32'(de_a),  32'(m_de));
        chk({tag, ".se_b"},   32'(se_b),  32'(m_se));
        chk({tag, ".de_b"},   32'(de_b),  32'(m_de));
        chk({tag, ".sc8"},    32'(sc_a),  32'(m_sc8));
        chk({tag, ".dc8"},    32'(dc_a),  32'(m_dc8));
        chk({tag, ".sc2"},    32'(sc_b),  32'(m_sc2));
        chk({tag, ".dc2"},    32'(dc_b),  32'(m_dc2));
    endtask

    task automatic mdl_reset();
        m_hold = '0; m_data = '0; m_se = 1'b0; m_de = 1'b0;
        m_sc8 = 0; m_dc8 = 0; m_sc2 = 0; m_dc2 = 0;
    endtask

    // Sends nbits of rx_cw MSB-first, checks the serial output each bit,
    // then drops ss. tx_new >= 0 writes that payload on bit 0.
    task automatic frame(input string tag, input logic [FW-1:0] rx_cw, input int nbits,
                         input int tx_new, input bit clr);
        logic [FW-1:0] tx_exp;
        logic [DW-1:0] d;
        int            cls;
        tx_exp = '0;
        for (int b = 0; b < nbits; b++) begin
            @(negedge clk);
            ss     = 1'b1;
            msg_in = rx_cw[FW-1-b];
            tx_we  = 1'b0;
            if (b == 0) begin
                if (tx_new >= 0) begin
                    tx_we          = 1'b1;
                    data_from_peri = DW'(tx_new);
                    m_hold         = DW'(tx_new);
                end
                tx_exp = mdl_encode(m_hold);
            end
            #1;
            chk({tag, ".txbit_a"}, 32'(mo_a), 32'(tx_exp[FW-1-b]));
            chk({tag, ".txbit_b"}, 32'(mo_b), 32'(tx_exp[FW-1-b]));
        end
        @(negedge clk);
        ss     = 1'b0;
        tx_we  = 1'b0;
        msg_in = 1'($urandom_range(0, 1));
        if (nbits == FW) begin
            chk({tag, ".rv_early"}, 32'(rv_a), 32'd0);
            cnt_clr = clr;
            mdl_decode(rx_cw, cls, d);
            if (cls != 2) m_data = d;
            m_se = (cls == 1);
            m_de = (cls == 2);
            if (clr) begin
                m_sc8 = 0; m_dc8 = 0; m_sc2 = 0; m_dc2 = 0;
            end else if (cls == 1) begin
                if (m_sc8 < 255) m_sc8++;
                if (m_sc2 < 3)   m_sc2++;
            end else if (cls == 2) begin
                if (m_dc8 < 255) m_dc8++;
                if (m_dc2 < 3)   m_dc2++;
            end
            @(negedge clk);
            cnt_clr = 1'b0;
            chk_outs({tag, ".dec"}, 1'b1);
            @(negedge clk);
            chk({tag, ".rv_after_a"}, 32'(rv_a), 32'd0);
            chk({tag, ".rv_after_b"}, 32'(rv_b), 32'd0);
        end else begin
            repeat (2) begin
                @(negedge clk);
                chk_outs({tag, ".abort"}, 1'b0);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [FW-1:0] cw;
        int            n;
        int            mode, p1, p2, nb, txn;
        bit            clr;

        n = 0;
        for (int p = 3; p < FW; p++) begin
            if ((p & (p - 1)) != 0) begin
                dpos[n] = p;
                n++;
            end
        end

        reset = 1'b1; ss = 1'b0; msg_in = 1'b0; tx_we = 1'b0; cnt_clr = 1'b0;
        data_from_peri = '0;
        mdl_reset();
        repeat (2) @(negedge clk);
        chk_outs("reset", 1'b0);
        reset = 1'b0;

        // load payload 0x001, then loop the expected codeword back
        @(negedge clk);
        tx_we = 1'b1; data_from_peri = 11'h001; m_hold = 11'h001;
        @(negedge clk);
        tx_we = 1'b0;
        frame("clean", 16'h000F, FW, -1, 1'b0);
        frame("sec_pos5", 16'h002F, FW, -1, 1'b0);
        frame("sec_pos0", 16'h000E, FW, -1, 1'b0);
        frame("ded", 16'h0028, FW, -1, 1'b0);
        frame("abort7", 16'h000F, 7, -1, 1'b0);
        frame("after_abort", 16'h000F, FW, -1, 1'b0);
        frame("abort15", 16'h002F, 15, -1, 1'b0);

        // saturation of the 2-bit counters
        for (int i = 0; i < 5; i++) frame("sat", 16'h002F, FW, -1, 1'b0);
        chk("sat.sc2_is_3", 32'(sc_b), 32'd3);

        // clear coinciding with a corrected-frame increment
        frame("clr_inc", 16'h002F, FW, -1, 1'b1);
        chk("clr_inc.sc2_zero", 32'(sc_b), 32'd0);

        // TX write coinciding with bit 0
        frame("tx_bypass", mdl_encode(11'h5A3), FW, 11'h2C6, 1'b0);

        // reset in the middle of a frame
        frame("pre_rst", 16'h0028, FW, -1, 1'b0);
        cw = mdl_encode(11'h3F1);
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            ss = 1'b1; msg_in = cw[FW-1-b];
        end
        #2 reset = 1'b1;
        mdl_reset();
        #1;
        chk_outs("mid_rst", 1'b0);
        @(negedge clk);
        reset = 1'b0; ss = 1'b0;
        frame("post_rst", 16'h000F, FW, -1, 1'b0);

        // standalone clear
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        m_sc8 = 0; m_dc8 = 0; m_sc2 = 0; m_dc2 = 0;
        chk_outs("idle_clr", 1'b0);

        // randomized frames
        for (int it = 0; it < 40; it++) begin
            cw   = mdl_encode(DW'($urandom_range(0, 2047)));
            mode = int'($urandom_range(0, 5));
            nb   = FW;
            txn  = -1;
            clr  = 1'b0;
            case (mode)
                1: begin
                    p1 = int'($urandom_range(0, FW - 1));
                    cw[p1] = ~cw[p1];
                end
                2: begin
                    p1 = int'($urandom_range(0, FW - 1));
                    p2 = (p1 + 1 + int'($urandom_range(0, FW - 2))) % FW;
                    cw[p1] = ~cw[p1];
                    cw[p2] = ~cw[p2];
                end
                3: nb  = int'($urandom_range(1, FW - 1));
                4: txn = int'($urandom_range(0, 2047));
                5: clr = 1'b1;
                default: begin
                    @(negedge clk);
                    tx_we = 1'b1;
                    data_from_peri = DW'($urandom_range(0, 2047));
                    m_hold = data_from_peri;
                    @(negedge clk);
                    tx_we = 1'b0;
                end
            endcase
            frame("rand", cw, nb, txn, clr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
